cpu_bus_master: RTL and testbench

CPU-side requester for the shared two-CPU memory system bus. It accepts one-at-a-time read/write commands from a CPU core and drives the bus request signals: `req`, `address`, `data_in`, `rw_select`. It waits for the arbiter's per-CPU `enable` grant, holds the transaction stable for the whole grant window and captures read data from the shared `data_out`. One instance sits on each CPU port (port 0 and port 1) between the core and the arbiter.

---
 rtl/cpu_bus_master.sv | 148 ++++++++++++++
 tb/tb_cpu_bus_master.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_master.sv
// CPU-side requester for the shared two-CPU memory bus: one command slot, a REQ/GRANT/DONE handshake
// with the arbiter, and registered outputs. Define CPU_BUS_MASTER_TIMEOUT_EN to abort stuck transactions.
module cpu_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic       cmd_rw_i,
   input  logic [7:0] cmd_addr_i,
   input  logic [7:0] cmd_wdata_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_rdata_o,
   output logic       rsp_err_o,
   output logic       req_o,
   output logic [7:0] address_o,
   output logic [7:0] data_in_o,
   output logic       rw_select_o,
   input  logic       enable_i,
   input  logic [7:0] bus_rdata_i
);

   typedef enum logic [1:0] {IDLE, REQ, GRANT, DONE} state_e;

   state_e     state_q, state_d;
   logic       slot_full_q, slot_full_d;
   logic       slot_rw_q, slot_rw_d;
   logic [7:0] slot_addr_q, slot_addr_d;
   logic [7:0] slot_wdata_q, slot_wdata_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_rdata_q, rsp_rdata_d;
   logic       req_q, req_d;
   logic [7:0] address_q, address_d;
   logic [7:0] data_in_q, data_in_d;
   logic       rw_select_q, rw_select_d;
   logic       busy_d;

`ifdef CPU_BUS_MASTER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_err_q, rsp_err_d;
   logic             timeout;

   assign timeout   = (state_q == REQ || state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign cnt_d     = (state_d != state_q || !(state_q == REQ || state_q == GRANT)) ? '0 : cnt_q + 1'b1;
   assign rsp_err_o = rsp_err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rsp_err_q <= rsp_err_d;
      end
   end
`else
   assign rsp_err_o = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      slot_full_d  = slot_full_q;
      slot_rw_d    = slot_rw_q;
      slot_addr_d  = slot_addr_q;
      slot_wdata_d = slot_wdata_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = 8'h00;

      case (state_q)
         IDLE:  if (slot_full_q) state_d = REQ;
         REQ:   if (enable_i) state_d = GRANT;
         GRANT: if (!enable_i) begin
            state_d     = DONE;
            rsp_rdata_d = slot_rw_q ? 8'h00 : bus_rdata_i;
         end
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

`ifdef CPU_BUS_MASTER_TIMEOUT_EN
      // A real grant edge or end-of-grant always wins over an abort in the same cycle.
      rsp_err_d = 1'b0;
      if (timeout && state_d == state_q) begin
         state_d   = DONE;
         rsp_err_d = 1'b1;
      end
`endif

      // Freeing the slot on DONE entry lets the core hand over the next command during rsp_valid.
      if (state_d == DONE && state_q != DONE) begin
         rsp_valid_d = 1'b1;
         slot_full_d = 1'b0;
      end

      if (cmd_valid_i && !slot_full_q) begin
         slot_full_d  = 1'b1;
         slot_rw_d    = cmd_rw_i;
         slot_addr_d  = cmd_addr_i;
         slot_wdata_d = cmd_wdata_i;
      end

      busy_d      = (state_d == REQ) || (state_d == GRANT);
      req_d       = busy_d;
      address_d   = busy_d ? slot_addr_q  : 8'h00;
      data_in_d   = busy_d ? slot_wdata_q : 8'h00;
      rw_select_d = busy_d ? slot_rw_q    : 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         slot_full_q  <= 1'b0;
         slot_rw_q    <= 1'b0;
         slot_addr_q  <= 8'h00;
         slot_wdata_q <= 8'h00;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= 8'h00;
         req_q        <= 1'b0;
         address_q    <= 8'h00;
         data_in_q    <= 8'h00;
         rw_select_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_full_q  <= slot_full_d;
         slot_rw_q    <= slot_rw_d;
         slot_addr_q  <= slot_addr_d;
         slot_wdata_q <= slot_wdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         req_q        <= req_d;
         address_q    <= address_d;
         data_in_q    <= data_in_d;
         rw_select_q  <= rw_select_d;
      end
   end

   assign cmd_ready_o = !slot_full_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign req_o       = req_q;
   assign address_o   = address_q;
   assign data_in_o   = data_in_q;
   assign rw_select_o = rw_select_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Scoreboard bench for cpu_bus_master: stimulus queues expected responses, a negedge monitor compares them.
module tb_cpu_bus_master;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_rw;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_err;
   logic [7:0] rsp_rdata;
   logic       req, rw_select, enable;
   logic [7:0] address, data_in, bus_rdata;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] rdata;
      logic       err;
   } rsp_t;
   rsp_t exp_q[$];

   always #5 clk = ~clk;

   cpu_bus_master #(.TIMEOUT_CYCLES(8)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_rw_i    (cmd_rw),
      .cmd_addr_i  (cmd_addr),
      .cmd_wdata_i (cmd_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .req_o       (req),
      .address_o   (address),
      .data_in_o   (data_in),
      .rw_select_o (rw_select),
      .enable_i    (enable),
      .bus_rdata_i (bus_rdata)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_req"},       8'(req),       8'h00);
      chk({tag, "_address"},   address,       8'h00);
      chk({tag, "_data_in"},   data_in,       8'h00);
      chk({tag, "_rw_select"}, 8'(rw_select), 8'h00);
      chk({tag, "_rsp_valid"}, 8'(rsp_valid), 8'h00);
      chk({tag, "_cmd_ready"}, 8'(cmd_ready), 8'h01);
   endtask

   task automatic chk_bus(input logic rw, input logic [7:0] a, input logic [7:0] d);
      chk("bus_req",       8'(req),       8'h01);
      chk("bus_address",   address,       a);
      chk("bus_data_in",   data_in,       d);
      chk("bus_rw_select", 8'(rw_select), 8'(rw));
      chk("busy_cmd_ready",8'(cmd_ready), 8'h00);
      chk("busy_rsp_quiet",8'(rsp_valid), 8'h00);
   endtask

   // Starts at a negedge with the slot empty; ends at the negedge of the rsp_valid cycle.
   task automatic txn(input logic rw, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rdata,
                      input int delay, input int len, input bit stall);
      chk("accept_ready", 8'(cmd_ready), 8'h01);
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
      exp_q.push_back('{rdata: (rw ? 8'h00 : rdata), err: 1'b0});
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("slot_req_low", 8'(req), 8'h00);
      chk("slot_full",    8'(cmd_ready), 8'h00);
      @(negedge clk);
      for (int i = 0; i < delay; i++) begin
         chk_bus(rw, a, d);
         if (stall) begin
            cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'h3C;
         end
         @(negedge clk);
      end
      chk_bus(rw, a, d);
      enable = 1'b1;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         chk_bus(rw, a, d);
      end
      if (!rw) bus_rdata = rdata;
      enable = 1'b0;
      @(negedge clk);
      bus_rdata = 8'hEE;
      chk("done_rsp_valid", 8'(rsp_valid), 8'h01);
      chk("done_req_low",   8'(req),       8'h00);
      chk("done_cmd_ready", 8'(cmd_ready), 8'h01);
      chk("done_address",   address,       8'h00);
   endtask

   always @(negedge clk) begin
      rsp_t e;
      if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rsp_valid rdata=%h err=%b, expected no response", rsp_rdata, rsp_err);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err",   8'(rsp_err), 8'(e.err));
            $display("rsp: rdata=%h err=%b (expected rdata=%h err=%b)", rsp_rdata, rsp_err, e.rdata, e.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
      enable = 1'b0; bus_rdata = 8'hEE;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      chk("reset_rsp_rdata", rsp_rdata, 8'h00);
      chk("reset_rsp_err",   8'(rsp_err), 8'h00);
      rst_n = 1'b1;
      @(negedge clk); chk_idle("post_reset");

      txn(1'b1, 8'h10, 8'hA5, 8'h00, 0, 4, 1'b0);   // write, grant held 4 cycles
      @(negedge clk); chk_idle("after_write");
      txn(1'b0, 8'h10, 8'h00, 8'hA5, 2, 1, 1'b0);   // read back A5
      @(negedge clk); chk_idle("after_read");
      txn(1'b0, 8'h22, 8'h00, 8'h5A, 12, 2, 1'b1);  // 12-cycle grant delay, second command stalled
      txn(1'b1, 8'h55, 8'h3C, 8'h00, 0, 1, 1'b0);   // the stalled command, accepted in rsp_valid cycle
      txn(1'b0, 8'h80, 8'h00, 8'hC3, 1, 3, 1'b0);   // back-to-back again
      @(negedge clk); chk_idle("after_b2b");
      txn(1'b0, 8'hFF, 8'h00, 8'hFF, 0, 1, 1'b0);   // minimum-latency read
      @(negedge clk); chk_idle("after_min");

      // Reset in the middle of a grant window: no response may ever appear.
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h33; cmd_wdata = 8'h00;
      @(negedge clk); cmd_valid = 1'b0;
      @(negedge clk); enable = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_reset_req", 8'(req), 8'h01);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("async_reset");
      chk("async_reset_rsp_rdata", rsp_rdata, 8'h00);
      enable = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk); chk_idle("post_midreset");
      end

`ifdef CPU_BUS_MASTER_TIMEOUT_EN
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h44; cmd_wdata = 8'h00;
      exp_q.push_back('{rdata: 8'h00, err: 1'b1});
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         if (i == 1) cmd_valid = 1'b0;
         chk("timeout_quiet", 8'(rsp_valid), 8'h00);
      end
      @(negedge clk);
      chk("timeout_rsp_valid", 8'(rsp_valid), 8'h01);
      chk("timeout_req_low",   8'(req),       8'h00);
      @(negedge clk); chk_idle("after_timeout");
`endif

      repeat (3) @(negedge clk);
      chk("rsp_queue_empty", 8'(exp_q.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
